stage_lvl_dly: RTL and testbench

//   Multi-level SUMP trigger stage with level gating, per-stage delay and full serial mode.

---
 rtl/logip_pkg.sv | 28 ++
 rtl/stage_lvl_dly_if.sv | 35 +++
 rtl/stage_ser_shft.sv | 47 ++++
 rtl/stage_lvl_dly.sv | 132 +++++++++++++
 tb/tb_stage_lvl_dly.sv | 312 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/logip_pkg.sv
`default_nettype none
// ============================================================================
// Module      : logip_pkg
// Description : Shared types and command-field layout for the trigger stages.
// Revision    : 1.0 - initial release
// ============================================================================
package logip_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ARMD = 2'd1,
        ST_DLY  = 2'd2,
        ST_DONE = 2'd3
    } stage_state_t;

    typedef logic [1:0] lvl_t;

    localparam int DLY_LSB   = 0;
    localparam int DLY_W_MAX = 16;
    localparam int LVL_LSB   = 16;
    localparam int LVL_W     = 2;
    localparam int CHL_LSB   = 20;
    localparam int CHL_W     = 5;
    localparam int SER_BIT   = 26;
    localparam int ACT_BIT   = 27;

endpackage
`default_nettype wire

// File: rtl/stage_lvl_dly_if.sv
`default_nettype none
// ============================================================================
// Module      : stage_lvl_dly_if
// Description : Command, sample and trigger-result bundle of one trigger stage.
// Revision    : 1.0 - initial release
// ============================================================================
interface stage_lvl_dly_if #(
    parameter int CHLS = 32
);
    import logip_pkg::*;

    logic [31:0]     cmd_i;
    logic            set_mask_i;
    logic            set_val_i;
    logic            set_cfg_i;
    logic            arm_i;
    lvl_t            lvl_i;
    logic            stb_i;
    logic [CHLS-1:0] smpls_i;
    logic            match_o;
    logic            run_o;
    logic            busy_o;

    modport master (
        output cmd_i, set_mask_i, set_val_i, set_cfg_i, arm_i, lvl_i, stb_i, smpls_i,
        input  match_o, run_o, busy_o
    );

    modport slave (
        input  cmd_i, set_mask_i, set_val_i, set_cfg_i, arm_i, lvl_i, stb_i, smpls_i,
        output match_o, run_o, busy_o
    );

endinterface
`default_nettype wire

// File: rtl/stage_ser_shft.sv
`default_nettype none
// ============================================================================
// Module      : stage_ser_shft
// Description : Serial-mode shift register with guarded channel select.
// Revision    : 1.0 - initial release
// ============================================================================
module stage_ser_shft
    import logip_pkg::*;
#(
    parameter int CHLS = 32,
    parameter int WSER = 32
) (
    input  wire logic             clk_i,
    input  wire logic             rst_i,
    input  wire logic             stb_i,
    input  wire logic [CHL_W-1:0] chl_i,
    input  wire logic [CHLS-1:0]  smpls_i,
    output logic      [WSER-1:0]  ser_vec_o
);

    logic            sel_bit;
    logic [WSER-1:0] shft_d;
    // Only the low WSER-1 history bits are ever observed, so only those are stored.
    logic [WSER-2:0] shft_q;

    always_comb begin
        sel_bit = 1'b0;
        for (int i = 0; i < CHLS; i++) begin
            if (chl_i == CHL_W'(i)) begin
                sel_bit = smpls_i[i];
            end
        end
    end

    assign shft_d    = {shft_q, sel_bit};
    assign ser_vec_o = shft_d;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            shft_q <= '0;
        end else if (stb_i) begin
            shft_q <= shft_d[WSER-2:0];
        end
    end

endmodule
`default_nettype wire

// File: rtl/stage_lvl_dly.sv
`default_nettype none
// ============================================================================
// Module      : stage_lvl_dly
// Description : Trigger stage with level gating, strobe delay and serial mode.
// Revision    : 1.0 - initial release
// ============================================================================
module stage_lvl_dly
    import logip_pkg::*;
#(
    parameter int CHLS = 32,
    parameter int WSER = 32,
    parameter int WDLY = 16
) (
    input wire logic       clk_i,
    input wire logic       rst_i,
    stage_lvl_dly_if.slave bus
);

    if (CHLS > WSER) begin : g_chk_chls
        $error("stage_lvl_dly: CHLS (%0d) must not exceed WSER (%0d)", CHLS, WSER);
    end
    if (WDLY > DLY_W_MAX) begin : g_chk_wdly
        $error("stage_lvl_dly: WDLY (%0d) must not exceed %0d", WDLY, DLY_W_MAX);
    end

    logic [WSER-1:0]  mask_q;
    logic [WSER-1:0]  val_q;
    logic [WDLY-1:0]  dly_q;
    lvl_t             lvl_q;
    logic [CHL_W-1:0] chl_q;
    logic             ser_q;
    logic             act_q;

    stage_state_t     state_q, state_d;
    logic [WDLY-1:0]  cnt_q, cnt_d;
    logic             match_q, run_q, busy_q;

    logic [WSER-1:0]  ser_vec;
    logic [WSER-1:0]  cv;
    logic             hit;
    logic             fire;

    stage_ser_shft #(
        .CHLS (CHLS),
        .WSER (WSER)
    ) u_ser_shft (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .stb_i     (bus.stb_i),
        .chl_i     (chl_q),
        .smpls_i   (bus.smpls_i),
        .ser_vec_o (ser_vec)
    );

    assign cv  = ser_q ? ser_vec : WSER'(bus.smpls_i);
    assign hit = bus.stb_i & ~|((cv ^ val_q) & mask_q) & (bus.lvl_i >= lvl_q);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        fire    = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (bus.arm_i) state_d = ST_ARMD;
            end
            ST_ARMD: begin
                if (hit) begin
                    if (dly_q == '0) begin
                        state_d = ST_DONE;
                        fire    = 1'b1;
                    end else begin
                        state_d = ST_DLY;
                        cnt_d   = dly_q - WDLY'(1);
                    end
                end
            end
            // Once qualified, only strobes are counted; level and match are not re-checked.
            ST_DLY: begin
                if (bus.stb_i) begin
                    if (cnt_q == '0) begin
                        state_d = ST_DONE;
                        fire    = 1'b1;
                    end else begin
                        cnt_d = cnt_q - WDLY'(1);
                    end
                end
            end
            ST_DONE: begin
                if (bus.arm_i) state_d = ST_ARMD;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            mask_q  <= '0;
            val_q   <= '0;
            dly_q   <= '0;
            lvl_q   <= '0;
            chl_q   <= '0;
            ser_q   <= 1'b0;
            act_q   <= 1'b0;
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            match_q <= 1'b0;
            run_q   <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            match_q <= fire;
            run_q   <= fire & act_q;
            busy_q  <= (state_d == ST_ARMD) || (state_d == ST_DLY);
            if (bus.set_mask_i) mask_q <= bus.cmd_i[WSER-1:0];
            if (bus.set_val_i)  val_q  <= bus.cmd_i[WSER-1:0];
            if (bus.set_cfg_i) begin
                dly_q <= bus.cmd_i[DLY_LSB +: WDLY];
                lvl_q <= bus.cmd_i[LVL_LSB +: LVL_W];
                chl_q <= bus.cmd_i[CHL_LSB +: CHL_W];
                ser_q <= bus.cmd_i[SER_BIT];
                act_q <= bus.cmd_i[ACT_BIT];
            end
        end
    end

    assign bus.match_o = match_q;
    assign bus.run_o   = run_q;
    assign bus.busy_o  = busy_q;

endmodule
`default_nettype wire

// File: tb/tb_stage_lvl_dly.sv
`default_nettype none
// ============================================================================
// Module      : tb_stage_lvl_dly
// Description : Scenario bench for stage_lvl_dly with an expectation queue.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_stage_lvl_dly;

    localparam int CHLS = 8;
    localparam int WSER = 32;
    localparam int WDLY = 16;

    typedef struct packed {
        logic       rst;
        logic       arm;
        logic       stb;
        logic [7:0] smp;
        logic [1:0] lvl;
        logic [2:0] exp;   // {match, run, busy} after the edge
    } step_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_run  = 0;
    int   n_fail = 0;
    logic prev_m = 1'b0;
    logic [2:0] exp_q[$];

    stage_lvl_dly_if #(.CHLS(CHLS)) bus ();

    stage_lvl_dly #(
        .CHLS (CHLS),
        .WSER (WSER),
        .WDLY (WDLY)
    ) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // A fired stage lands in DONE, so match_o may never stay high two cycles.
    always @(negedge clk) begin
        if (!rst && bus.match_o === 1'b1) begin
            n_run++;
            if (prev_m === 1'b1) begin
                n_fail++;
                $display("FAIL match_pulse: match_o=1 on consecutive cycles, required single pulse");
            end
        end
        prev_m = bus.match_o;
    end

    function automatic step_t mk(input logic r, input logic a, input logic s,
                                 input logic [7:0] d, input logic [1:0] l, input logic [2:0] e);
        mk = '{rst: r, arm: a, stb: s, smp: d, lvl: l, exp: e};
    endfunction

    task automatic apply(input step_t st);
        rst         = st.rst;
        bus.arm_i   = st.arm;
        bus.stb_i   = st.stb;
        bus.smpls_i = st.smp;
        bus.lvl_i   = st.lvl;
        exp_q.push_back(st.exp);
        @(posedge clk);
        #1;
        bus.arm_i = 1'b0;
        bus.stb_i = 1'b0;
        rst       = 1'b0;
    endtask

    // kind: 0 = mask, 1 = value, 2 = config
    task automatic write_reg(input int kind, input logic [31:0] data);
        bus.cmd_i      = data;
        bus.set_mask_i = (kind == 0);
        bus.set_val_i  = (kind == 1);
        bus.set_cfg_i  = (kind == 2);
        @(posedge clk);
        #1;
        bus.set_mask_i = 1'b0;
        bus.set_val_i  = 1'b0;
        bus.set_cfg_i  = 1'b0;
    endtask

    task automatic test_reset();
        logic [2:0] o;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        o = {bus.match_o, bus.run_o, bus.busy_o};
        n_run++;
        if ($isunknown(o)) begin
            n_fail++;
            $display("FAIL reset_x: outputs=%b required no X", o);
        end
        n_run++;
        if (o !== 3'b000) begin
            n_fail++;
            $display("FAIL reset_out: match/run/busy=%b required 000", o);
        end
        rst = 1'b0;
        @(posedge clk);
        #1;
        n_run++;
        if (bus.busy_o !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_idle: busy_o=%b required 0", bus.busy_o);
        end
    endtask

    task automatic test_parallel();
        step_t s[$];
        logic [2:0] e;
        write_reg(0, 32'h0000_00FF);
        write_reg(1, 32'h0000_00A5);
        write_reg(2, 32'h0);
        s.push_back(mk(0, 1, 0, 8'h00, 2'd0, 3'b001));
        s.push_back(mk(0, 0, 1, 8'h12, 2'd0, 3'b001));
        s.push_back(mk(0, 0, 1, 8'hA5, 2'd0, 3'b100));
        s.push_back(mk(0, 0, 1, 8'hA5, 2'd0, 3'b000));
        foreach (s[i]) begin
            apply(s[i]);
            e = exp_q.pop_front();
            n_run++;
            if ({bus.match_o, bus.run_o, bus.busy_o} !== e) begin
                n_fail++;
                $display("FAIL parallel step %0d: match/run/busy=%b required %b",
                         i, {bus.match_o, bus.run_o, bus.busy_o}, e);
            end
        end
    endtask

    task automatic test_level();
        step_t s[$];
        logic [2:0] e;
        write_reg(2, 32'h0002_0000);
        s.push_back(mk(0, 1, 0, 8'h00, 2'd1, 3'b001));
        s.push_back(mk(0, 0, 1, 8'hA5, 2'd1, 3'b001));
        s.push_back(mk(0, 0, 1, 8'hA5, 2'd2, 3'b100));
        foreach (s[i]) begin
            apply(s[i]);
            e = exp_q.pop_front();
            n_run++;
            if ({bus.match_o, bus.run_o, bus.busy_o} !== e) begin
                n_fail++;
                $display("FAIL level step %0d: match/run/busy=%b required %b",
                         i, {bus.match_o, bus.run_o, bus.busy_o}, e);
            end
        end
    endtask

    task automatic test_delay();
        step_t s[$];
        logic [2:0] e;
        write_reg(2, 32'h0002_0003);    // dly=3, lvl=2
        s.push_back(mk(0, 1, 0, 8'h00, 2'd2, 3'b001));
        s.push_back(mk(0, 0, 1, 8'hA5, 2'd2, 3'b001));  // hit strobe
        s.push_back(mk(0, 0, 0, 8'h00, 2'd0, 3'b001));
        s.push_back(mk(0, 0, 1, 8'h00, 2'd0, 3'b001));  // strobe 1
        s.push_back(mk(0, 0, 0, 8'h00, 2'd0, 3'b001));
        s.push_back(mk(0, 0, 0, 8'h00, 2'd0, 3'b001));
        s.push_back(mk(0, 0, 1, 8'h00, 2'd0, 3'b001));  // strobe 2
        s.push_back(mk(0, 0, 0, 8'h00, 2'd0, 3'b001));
        s.push_back(mk(0, 0, 1, 8'h00, 2'd0, 3'b100));  // strobe 3 fires
        s.push_back(mk(0, 0, 0, 8'h00, 2'd0, 3'b000));
        foreach (s[i]) begin
            apply(s[i]);
            e = exp_q.pop_front();
            n_run++;
            if ({bus.match_o, bus.run_o, bus.busy_o} !== e) begin
                n_fail++;
                $display("FAIL delay step %0d: match/run/busy=%b required %b",
                         i, {bus.match_o, bus.run_o, bus.busy_o}, e);
            end
        end
    endtask

    task automatic test_serial();
        step_t s[$];
        logic [2:0] e;
        write_reg(0, 32'h0000_000F);
        write_reg(1, 32'h0000_000B);
        write_reg(2, 32'h0450_0000);    // ser=1, chl=5
        for (int k = 0; k < 4; k++) s.push_back(mk(0, 0, 1, 8'h00, 2'd0, 3'b000));
        s.push_back(mk(0, 1, 0, 8'h00, 2'd0, 3'b001));
        s.push_back(mk(0, 0, 1, 8'h20, 2'd0, 3'b001));
        s.push_back(mk(0, 0, 1, 8'h00, 2'd0, 3'b001));
        s.push_back(mk(0, 0, 1, 8'h20, 2'd0, 3'b001));
        s.push_back(mk(0, 0, 1, 8'h20, 2'd0, 3'b100));
        foreach (s[i]) begin
            apply(s[i]);
            e = exp_q.pop_front();
            n_run++;
            if ({bus.match_o, bus.run_o, bus.busy_o} !== e) begin
                n_fail++;
                $display("FAIL serial step %0d: match/run/busy=%b required %b",
                         i, {bus.match_o, bus.run_o, bus.busy_o}, e);
            end
        end
        // Channel 31 is beyond CHLS, so all-ones samples must still shift zeros.
        s.delete();
        write_reg(1, 32'h0);
        write_reg(2, 32'h05F0_0000);    // ser=1, chl=31
        s.push_back(mk(0, 1, 0, 8'h00, 2'd0, 3'b001));
        s.push_back(mk(0, 0, 1, 8'hFF, 2'd0, 3'b001));
        s.push_back(mk(0, 0, 1, 8'hFF, 2'd0, 3'b001));
        s.push_back(mk(0, 0, 1, 8'hFF, 2'd0, 3'b001));
        s.push_back(mk(0, 0, 1, 8'hFF, 2'd0, 3'b100));
        foreach (s[i]) begin
            apply(s[i]);
            e = exp_q.pop_front();
            n_run++;
            if ({bus.match_o, bus.run_o, bus.busy_o} !== e) begin
                n_fail++;
                $display("FAIL serial_oor step %0d: match/run/busy=%b required %b",
                         i, {bus.match_o, bus.run_o, bus.busy_o}, e);
            end
        end
    endtask

    task automatic test_run_rearm();
        step_t s[$];
        logic [2:0] e;
        write_reg(0, 32'h0000_00FF);
        write_reg(1, 32'h0000_00A5);
        write_reg(2, 32'h0800_0000);    // act=1
        s.push_back(mk(0, 1, 0, 8'h00, 2'd0, 3'b001));
        s.push_back(mk(0, 0, 1, 8'hA5, 2'd0, 3'b110));
        s.push_back(mk(0, 1, 0, 8'h00, 2'd0, 3'b001));  // re-arm from DONE
        s.push_back(mk(0, 0, 1, 8'hA5, 2'd0, 3'b110));
        foreach (s[i]) begin
            apply(s[i]);
            e = exp_q.pop_front();
            n_run++;
            if ({bus.match_o, bus.run_o, bus.busy_o} !== e) begin
                n_fail++;
                $display("FAIL run_rearm step %0d: match/run/busy=%b required %b",
                         i, {bus.match_o, bus.run_o, bus.busy_o}, e);
            end
        end
        s.delete();
        write_reg(2, 32'h0800_0002);    // act=1, dly=2
        s.push_back(mk(0, 1, 0, 8'h00, 2'd0, 3'b001));
        s.push_back(mk(0, 0, 1, 8'hA5, 2'd0, 3'b001));
        s.push_back(mk(0, 1, 1, 8'h00, 2'd0, 3'b001));  // arm in DLY ignored
        s.push_back(mk(0, 0, 1, 8'h00, 2'd0, 3'b110));
        s.push_back(mk(0, 0, 0, 8'h00, 2'd0, 3'b000));
        foreach (s[i]) begin
            apply(s[i]);
            e = exp_q.pop_front();
            n_run++;
            if ({bus.match_o, bus.run_o, bus.busy_o} !== e) begin
                n_fail++;
                $display("FAIL arm_in_dly step %0d: match/run/busy=%b required %b",
                         i, {bus.match_o, bus.run_o, bus.busy_o}, e);
            end
        end
    endtask

    task automatic test_reset_mid_dly();
        step_t s[$];
        logic [2:0] e;
        write_reg(2, 32'h0800_0003);    // act=1, dly=3
        s.push_back(mk(0, 1, 0, 8'h00, 2'd0, 3'b001));
        s.push_back(mk(0, 0, 1, 8'hA5, 2'd0, 3'b001));  // cnt=2
        s.push_back(mk(1, 0, 1, 8'hA5, 2'd0, 3'b000));  // reset with a strobe
        for (int k = 0; k < 4; k++) s.push_back(mk(0, 0, 1, 8'hA5, 2'd0, 3'b000));
        // Cleared config: mask 0 hits any strobe, dly 0, act 0.
        s.push_back(mk(0, 1, 0, 8'h00, 2'd0, 3'b001));
        s.push_back(mk(0, 0, 1, 8'h00, 2'd0, 3'b100));
        foreach (s[i]) begin
            apply(s[i]);
            e = exp_q.pop_front();
            n_run++;
            if ({bus.match_o, bus.run_o, bus.busy_o} !== e) begin
                n_fail++;
                $display("FAIL reset_dly step %0d: match/run/busy=%b required %b",
                         i, {bus.match_o, bus.run_o, bus.busy_o}, e);
            end
        end
    endtask

    initial begin
        bus.cmd_i      = '0;
        bus.set_mask_i = 1'b0;
        bus.set_val_i  = 1'b0;
        bus.set_cfg_i  = 1'b0;
        bus.arm_i      = 1'b0;
        bus.lvl_i      = '0;
        bus.stb_i      = 1'b0;
        bus.smpls_i    = '0;
        test_reset();
        test_parallel();
        test_level();
        test_delay();
        test_serial();
        test_run_rearm();
        test_reset_mid_dly();
        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
